// File: rtl/pconv_sched_pkg.sv
// Shared definitions for the pointwise-convolution layer sequencer:
// FSM state encoding, address-width helper and default datapath latency.
package pconv_pkg;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_LOAD  = 3'd1,
        S_LATCH = 3'd2,
        S_RUN   = 3'd3,
        S_DRAIN = 3'd4,
        S_FIN   = 3'd5
    } state_t;

    localparam int PCONV_LAT_DEF = 3;

    // Width of an index over n items; never less than one bit.
    function automatic int addr_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/pconv_sched.sv
// Layer sequencer for the 1x1 conv datapath: per output channel, loads weight/bias/shift
// once, streams every pixel through the datapath and writes results. PCONV_SCHED_GAP_EN inserts an idle cycle between reads.
module pconv_sched
    import pconv_pkg::*;
#(
    parameter int N             = 16,
    parameter int INPUT_CHANNEL = 3,
    parameter int OUT_CHANNEL   = 8,
    parameter int PIXELS        = 784,
    parameter int PCONV_LAT     = PCONV_LAT_DEF,
    localparam int PA = addr_w(PIXELS),
    localparam int CA = addr_w(OUT_CHANNEL),
    localparam int OA = addr_w(OUT_CHANNEL * PIXELS),
    localparam int VW = INPUT_CHANNEL * N
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic          abort,
    output logic          busy,
    output logic          done,
    output logic          err,
    output logic          w_rd_en,
    output logic [CA-1:0] w_rd_addr,
    input  logic [VW-1:0] w_rd_data,
    input  logic [31:0]   b_rd_data,
    input  logic [4:0]    s_rd_data,
    output logic          in_rd_en,
    output logic [PA-1:0] in_rd_addr,
    input  logic [VW-1:0] in_rd_data,
    output logic          pconv_ce,
    output logic          pconv_input_vld,
    output logic [VW-1:0] pconv_input_din,
    output logic [VW-1:0] pconv_weight_din,
    output logic [31:0]   pconv_bias_din,
    output logic [4:0]    pconv_shift_din,
    input  logic [N-1:0]  pconv_dout,
    input  logic          pconv_dout_vld,
    output logic          out_we,
    output logic [OA-1:0] out_addr,
    output logic [N-1:0]  out_data
);

    if (PCONV_LAT < 1) begin : g_bad_lat
        $error("PCONV_LAT must be at least 1");
    end

    state_t        state_q, state_d;
    logic [CA-1:0] oc_q, oc_d;
    logic [PA-1:0] pix_q, pix_d;
    logic [PA:0]   wr_cnt_q, wr_cnt_d;
    logic [VW-1:0] weight_q, weight_d;
    logic [31:0]   bias_q, bias_d;
    logic [4:0]    shift_q, shift_d;
    logic          err_q, err_d;
    logic          vld_q, vld_d;
    logic          abort_act;
    logic          wr_state;
`ifdef PCONV_SCHED_GAP_EN
    logic          gap_q, gap_d;
`endif

    assign busy      = (state_q != S_IDLE);
    assign abort_act = abort && busy;
    assign wr_state  = (state_q == S_RUN) || (state_q == S_DRAIN) || (state_q == S_FIN);

    always_comb begin
        state_d  = state_q;
        oc_d     = oc_q;
        pix_d    = pix_q;
        wr_cnt_d = wr_cnt_q;
        weight_d = weight_q;
        bias_d   = bias_q;
        shift_d  = shift_q;
        err_d    = err_q;
        w_rd_en  = 1'b0;
        in_rd_en = 1'b0;
        done     = 1'b0;
        out_we   = 1'b0;
`ifdef PCONV_SCHED_GAP_EN
        gap_d    = gap_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (start && !abort) begin
                    state_d = S_LOAD;
                    oc_d    = '0;
                    err_d   = 1'b0;
                end
            end
            S_LOAD: begin
                w_rd_en = 1'b1;
                state_d = S_LATCH;
            end
            S_LATCH: begin
                weight_d = w_rd_data;
                bias_d   = b_rd_data;
                shift_d  = s_rd_data;
                pix_d    = '0;
                wr_cnt_d = '0;
`ifdef PCONV_SCHED_GAP_EN
                gap_d    = 1'b0;
`endif
                state_d  = S_RUN;
            end
            S_RUN: begin
`ifdef PCONV_SCHED_GAP_EN
                in_rd_en = !gap_q;
                gap_d    = !gap_q;
`else
                in_rd_en = 1'b1;
`endif
                if (in_rd_en) begin
                    if (pix_q == PA'(PIXELS - 1)) state_d = S_DRAIN;
                    else                          pix_d   = pix_q + 1'b1;
                end
            end
            S_DRAIN: begin
                // Parameters for the next channel load only after every result has landed.
                if (wr_cnt_q == (PA + 1)'(PIXELS)) begin
                    if (oc_q == CA'(OUT_CHANNEL - 1)) begin
                        state_d = S_FIN;
                    end else begin
                        oc_d    = oc_q + 1'b1;
                        state_d = S_LOAD;
                    end
                end
            end
            S_FIN: begin
                done    = 1'b1;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase

        if (pconv_dout_vld) begin
            if (wr_state && (wr_cnt_q != (PA + 1)'(PIXELS))) begin
                out_we   = 1'b1;
                wr_cnt_d = wr_cnt_q + 1'b1;
            end else begin
                err_d = 1'b1;
            end
        end

        if (abort_act) begin
            state_d  = S_IDLE;
            w_rd_en  = 1'b0;
            in_rd_en = 1'b0;
            out_we   = 1'b0;
            done     = 1'b0;
            wr_cnt_d = wr_cnt_q;
        end
    end

    assign vld_d = in_rd_en;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= S_IDLE;
            oc_q     <= '0;
            pix_q    <= '0;
            wr_cnt_q <= '0;
            weight_q <= '0;
            bias_q   <= '0;
            shift_q  <= '0;
            err_q    <= 1'b0;
            vld_q    <= 1'b0;
`ifdef PCONV_SCHED_GAP_EN
            gap_q    <= 1'b0;
`endif
        end else begin
            state_q  <= state_d;
            oc_q     <= oc_d;
            pix_q    <= pix_d;
            wr_cnt_q <= wr_cnt_d;
            weight_q <= weight_d;
            bias_q   <= bias_d;
            shift_q  <= shift_d;
            err_q    <= err_d;
            vld_q    <= vld_d;
`ifdef PCONV_SCHED_GAP_EN
            gap_q    <= gap_d;
`endif
        end
    end

    assign err              = err_q;
    assign pconv_ce         = busy;
    assign pconv_input_vld  = vld_q && !abort_act;
    assign pconv_input_din  = in_rd_data;
    assign pconv_weight_din = weight_q;
    assign pconv_bias_din   = bias_q;
    assign pconv_shift_din  = shift_q;
    assign w_rd_addr        = w_rd_en ? oc_q : '0;
    assign in_rd_addr       = in_rd_en ? pix_q : '0;
    assign out_addr         = out_we ? (OA'(oc_q) * OA'(PIXELS) + OA'(wr_cnt_q)) : '0;
    assign out_data         = out_we ? pconv_dout : '0;

endmodule

// File: tb/tb_pconv_sched.sv
// Bench for pconv_sched: memory and datapath models, write scoreboard, table-driven layer runs
// plus hand-written sequences for abort, idle-valid error and a held start.
module tb_pconv_sched;

    localparam int N   = 16;
    localparam int IC  = 3;
    localparam int OC  = 2;
    localparam int P   = 4;
    localparam int LAT = 3;
    localparam int PA  = $clog2(P);
    localparam int CA  = $clog2(OC);
    localparam int OA  = $clog2(OC * P);
    localparam int VW  = IC * N;
`ifdef PCONV_SCHED_GAP_EN
    localparam int EXP_LAT = 29;
    localparam int STEP    = 2;
`else
    localparam int EXP_LAT = 23;
    localparam int STEP    = 1;
`endif

    logic          clk, rst, start, abort, inj;
    logic          busy, done, err;
    logic          w_rd_en, in_rd_en;
    logic [CA-1:0] w_rd_addr;
    logic [PA-1:0] in_rd_addr;
    logic [VW-1:0] w_rd_data, in_rd_data;
    logic [31:0]   b_rd_data;
    logic [4:0]    s_rd_data;
    logic          pconv_ce, pconv_input_vld, pconv_dout_vld;
    logic [VW-1:0] pconv_input_din, pconv_weight_din;
    logic [31:0]   pconv_bias_din;
    logic [4:0]    pconv_shift_din;
    logic [N-1:0]  pconv_dout, out_data;
    logic          out_we;
    logic [OA-1:0] out_addr;

    pconv_sched #(
        .N(N), .INPUT_CHANNEL(IC), .OUT_CHANNEL(OC), .PIXELS(P), .PCONV_LAT(LAT)
    ) dut (
        .clk(clk), .rst(rst), .start(start), .abort(abort),
        .busy(busy), .done(done), .err(err),
        .w_rd_en(w_rd_en), .w_rd_addr(w_rd_addr), .w_rd_data(w_rd_data),
        .b_rd_data(b_rd_data), .s_rd_data(s_rd_data),
        .in_rd_en(in_rd_en), .in_rd_addr(in_rd_addr), .in_rd_data(in_rd_data),
        .pconv_ce(pconv_ce), .pconv_input_vld(pconv_input_vld),
        .pconv_input_din(pconv_input_din), .pconv_weight_din(pconv_weight_din),
        .pconv_bias_din(pconv_bias_din), .pconv_shift_din(pconv_shift_din),
        .pconv_dout(pconv_dout), .pconv_dout_vld(pconv_dout_vld),
        .out_we(out_we), .out_addr(out_addr), .out_data(out_data)
    );

    // Clock / cycle counter
    initial clk = 1'b0;
    always #5 clk = ~clk;
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Parameter tables and input image
    logic [N-1:0]     w_tab [OC] = '{16'h00A5, 16'h005A};
    logic [31:0]      b_tab [OC] = '{32'd100, 32'd200};
    logic [4:0]       s_tab [OC] = '{5'd4, 5'd2};
    logic [N-1:0]     img   [P];
    logic [2*N-1:0]   lane_hi = 32'hDEAD_BEEF;

    always @(posedge clk) begin
        if (rst) begin
            w_rd_data  <= '0;
            b_rd_data  <= '0;
            s_rd_data  <= '0;
            in_rd_data <= '0;
        end else begin
            if (w_rd_en) begin
                w_rd_data <= {32'h0, w_tab[w_rd_addr]};
                b_rd_data <= b_tab[w_rd_addr];
                s_rd_data <= s_tab[w_rd_addr];
            end
            if (in_rd_en) in_rd_data <= {lane_hi, img[in_rd_addr]};
        end
    end

    // Behavioural datapath: lane0 plus 16 for the channel whose bias is 200, LAT cycles later.
    logic [N:0] pipe [LAT];
    always @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < LAT; i++) pipe[i] <= '0;
        end else begin
            pipe[0] <= {pconv_input_vld & pconv_ce,
                        pconv_input_din[N-1:0] + ((pconv_bias_din == 32'd200) ? N'(16) : N'(0))};
            for (int i = 1; i < LAT; i++) pipe[i] <= pipe[i-1];
        end
    end
    assign pconv_dout_vld = pipe[LAT-1][N] | inj;
    assign pconv_dout     = pipe[LAT-1][N-1:0];

    // Scoreboard and counters
    typedef logic [OA+N-1:0] exp_t;
    exp_t exp_q[$];
    exp_t e_mon;
    int   checks = 0;
    int   errors = 0;
    int   done_cnt, first_done, second_done, issue_cnt, rd_cnt, last_rd, idle_cnt;
    int   extra_wr, post_abort_wr;
    bit   aborted;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, expv, cyc);
        end
    endtask

    always @(negedge clk) begin
        if (!rst) begin
            if (done) begin
                if (done_cnt == 0) first_done = cyc;
                else               second_done = cyc;
                done_cnt++;
            end
            if (pconv_input_vld) begin
                chk("issue_bias", pconv_bias_din, b_tab[(issue_cnt / P) % OC]);
                issue_cnt++;
            end
            if (in_rd_en) begin
                if (rd_cnt % P != 0) chk("rd_spacing", cyc - last_rd, STEP);
                chk("rd_addr", in_rd_addr, rd_cnt % P);
                last_rd = cyc;
                rd_cnt++;
            end
            if (out_we) begin
                if (aborted) begin
                    post_abort_wr++;
                end else if (exp_q.size() == 0) begin
                    extra_wr++;
                end else begin
                    e_mon = exp_q.pop_front();
                    chk("out_addr", out_addr, e_mon[OA+N-1:N]);
                    chk("out_data", out_data, e_mon[N-1:0]);
                    chk("out_bias", pconv_bias_din, b_tab[e_mon[OA+N-1:N] / P]);
                    chk("out_weight", pconv_weight_din[N-1:0], w_tab[e_mon[OA+N-1:N] / P]);
                    chk("out_shift", pconv_shift_din, s_tab[e_mon[OA+N-1:N] / P]);
                end
            end
            if (!busy) idle_cnt++;
        end
    end

    task automatic clear_mon();
        done_cnt = 0; issue_cnt = 0; rd_cnt = 0; idle_cnt = 0;
        extra_wr = 0; post_abort_wr = 0; aborted = 0;
        exp_q.delete();
    endtask

    task automatic push_layer();
        for (int oc = 0; oc < OC; oc++)
            for (int p = 0; p < P; p++)
                exp_q.push_back({OA'(oc * P + p), N'(img[p] + N'(16 * oc))});
    endtask

    typedef struct {
        int abort_after;
        bit rand_img;
        bit inject;
        int exp_done;
        int exp_lat;
    } row_t;
    row_t rows [8];

    task automatic run_row(input row_t r);
        int c0;
        for (int p = 0; p < P; p++) img[p] = r.rand_img ? N'($urandom) : N'(p);
        clear_mon();
        if (r.inject) begin
            @(posedge clk); #1 inj = 1'b1;
            @(posedge clk); #1 inj = 1'b0;
            @(negedge clk);
            chk("err_set_idle", err, 1);
            repeat (3) @(negedge clk);
            chk("err_sticky", err, 1);
        end
        push_layer();
        @(posedge clk); #1 start = 1'b1; c0 = cyc;
        @(posedge clk); #1 start = 1'b0;
        if (r.inject) begin
            @(negedge clk);
            chk("err_clear_on_start", err, 0);
        end
        if (r.abort_after > 0) begin
            while (cyc < c0 + r.abort_after) begin
                @(posedge clk); #1;
            end
            abort = 1'b1; aborted = 1'b1;
            @(posedge clk); #1 abort = 1'b0;
            @(negedge clk);
            chk("abort_busy", busy, 0);
            repeat (LAT + 4) @(negedge clk);
            chk("abort_late_writes", post_abort_wr, 0);
            exp_q.delete();
        end else begin
            for (int i = 0; i < 300 && done_cnt == 0; i++) @(negedge clk);
            repeat (5) @(negedge clk);
            chk("done_latency", first_done - c0, r.exp_lat);
            chk("writes_left", exp_q.size(), 0);
            chk("busy_after", busy, 0);
            chk("err_clean", err, 0);
        end
        chk("done_count", done_cnt, r.exp_done);
        chk("extra_writes", extra_wr, 0);
    endtask

    initial begin
        int c0;
        int n_layers;
        rst = 1'b1; start = 1'b0; abort = 1'b0; inj = 1'b0;
        clear_mon();
        for (int p = 0; p < P; p++) img[p] = '0;

        rows[0] = '{0, 1'b0, 1'b0, 1, EXP_LAT};
        rows[1] = '{0, 1'b1, 1'b0, 1, EXP_LAT};
        rows[2] = '{5, 1'b0, 1'b0, 0, 0};
        rows[3] = '{0, 1'b0, 1'b0, 1, EXP_LAT};
        rows[4] = '{0, 1'b0, 1'b1, 1, EXP_LAT};
        rows[5] = '{int'($urandom_range(1, EXP_LAT - 1)), 1'b1, 1'b0, 0, 0};
        rows[6] = '{int'($urandom_range(1, EXP_LAT - 1)), 1'b1, 1'b0, 0, 0};
        rows[7] = '{0, 1'b1, 1'b0, 1, EXP_LAT};

        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_err", err, 0);
        chk("rst_w_rd_en", w_rd_en, 0);
        chk("rst_in_rd_en", in_rd_en, 0);
        chk("rst_out_we", out_we, 0);
        chk("rst_ce", pconv_ce, 0);
        chk("rst_input_vld", pconv_input_vld, 0);
        chk("rst_bias", pconv_bias_din, 0);
        chk("rst_weight", pconv_weight_din, 0);
        chk("rst_out_addr", out_addr, 0);

        for (int i = 0; i < 8; i++) run_row(rows[i]);

        // Start held high for 30 cycles; a second layer only begins once IDLE is reached.
        for (int p = 0; p < P; p++) img[p] = N'(p);
        clear_mon();
        n_layers = (EXP_LAT + 1 <= 29) ? 2 : 1;
        for (int k = 0; k < n_layers; k++) push_layer();
        @(posedge clk); #1 start = 1'b1; c0 = cyc; idle_cnt = 0;
        repeat (30) @(posedge clk);
        #1 start = 1'b0;
        chk("held_idle_cycles", idle_cnt, n_layers);
        for (int i = 0; i < 300 && done_cnt < n_layers; i++) @(negedge clk);
        repeat (5) @(negedge clk);
        chk("held_done_count", done_cnt, n_layers);
        chk("held_first_done", first_done - c0, EXP_LAT);
        if (n_layers == 2) chk("held_second_done", second_done - c0, 2 * EXP_LAT + 1);
        chk("held_writes_left", exp_q.size(), 0);
        chk("held_extra_writes", extra_wr, 0);
        chk("held_busy_after", busy, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
        $fatal(1, "watchdog");
    end

endmodule
